// File: rtl/csa_pkg.sv
// Shared constants and the row type for the carry-save reduction tree and its resolver.
package csa_pkg;
  localparam int unsigned WIDTH_DEFAULT  = 64;
  localparam int unsigned SLICES_DEFAULT = 4;

  typedef logic [WIDTH_DEFAULT-1:0] row_t;
endpackage

// File: rtl/slice_add.sv
// Combinational W-bit adder with carry-in and carry-out; one instance per resolver slice.
module slice_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

endmodule

// File: rtl/csa_resolve.sv
// Carry-pipelined resolver: adds the sum and carry rows of a carry-save pair over SLICES slices.
// Define CSA_RESOLVE_OVF_EN to pipeline the final carry-out onto out_ovf; otherwise out_ovf is 0.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned SLICES = SLICES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf
);

  localparam int unsigned SW = WIDTH / SLICES;

  logic [SLICES-1:0] valid_q, valid_d;
  logic [SLICES-2:0] carry_q, carry_d, cout_c;
  logic [SLICES-1:0] cin_c;

  // Valid shift register and inter-slice carry registers
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    if (en) begin
      valid_d = {valid_q[SLICES-2:0], in_valid};
      carry_d = cout_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q[SLICES-1];
  assign cin_c     = {carry_q, 1'b0};

`ifdef CSA_RESOLVE_OVF_EN
  logic last_cout_c, ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (en) ovf_d = last_cout_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    // Slice k result waits SLICES-k stages so every slice lands in the output together
    localparam int unsigned DEPTH = SLICES - k;

    logic [SW-1:0] a_c, b_c, sum_c;
    logic [SW-1:0] res_q [DEPTH];
    logic [SW-1:0] res_d [DEPTH];

    if (k == 0) begin : g_direct
      assign a_c = in_sum[SW-1:0];
      assign b_c = in_carry[SW-1:0];
    end else begin : g_skew
      logic [SW-1:0] a_q [k];
      logic [SW-1:0] a_d [k];
      logic [SW-1:0] b_q [k];
      logic [SW-1:0] b_d [k];

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en) begin
          a_d[0] = in_sum[k*SW +: SW];
          b_d[0] = in_carry[k*SW +: SW];
          for (int i = 1; i < k; i++) begin
            a_d[i] = a_q[i-1];
            b_d[i] = b_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_c = a_q[k-1];
      assign b_c = b_q[k-1];
    end

    if (k < SLICES - 1) begin : g_mid
      slice_add #(.W(SW)) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (cin_c[k]),
        .sum  (sum_c),
        .cout (cout_c[k])
      );
    end else begin : g_last
`ifdef CSA_RESOLVE_OVF_EN
      slice_add #(.W(SW)) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (cin_c[k]),
        .sum  (sum_c),
        .cout (last_cout_c)
      );
`else
      logic cout_unused;
      slice_add #(.W(SW)) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (cin_c[k]),
        .sum  (sum_c),
        .cout (cout_unused)
      );
`endif
    end

    always_comb begin
      res_d = res_q;
      if (en) begin
        res_d[0] = sum_c;
        for (int i = 1; i < int'(DEPTH); i++) res_d[i] = res_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) res_q[i] <= '0;
      end else begin
        res_q <= res_d;
      end
    end

    assign out[k*SW +: SW] = res_q[DEPTH-1];
  end

endmodule

// File: tb/tb_csa_resolve.sv
// Self-checking bench for csa_resolve: directed literal cases plus a whole-result delay-line model.
module tb_csa_resolve;
  localparam int unsigned W  = 64;
  localparam int unsigned SL = 4;
`ifdef CSA_RESOLVE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, in_valid;
  logic [W-1:0] in_sum, in_carry, out;
  logic         out_valid, out_ovf;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit model_on = 1'b0;
  bit rec_on   = 1'b0;

  // Model: each accepted op's full (W+1)-bit sum travels SL enabled edges as one record
  logic         mv [SL];
  logic [W:0]   mr [SL];
  int           rec_cyc [$];
  logic [W-1:0] rec_out [$];

  csa_resolve #(.WIDTH(W), .SLICES(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out       (out),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SL; i++) begin
        mv[i] = 1'b0;
        mr[i] = '0;
      end
    end else if (en) begin
      for (int i = SL - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = in_valid;
      mr[0] = {1'b0, in_sum} + {1'b0, in_carry};
    end
  end

  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("model_valid", 65'(out_valid), 65'(mv[SL-1]));
      if (mv[SL-1]) begin
        chk("model_out", 65'(out), 65'(mr[SL-1][W-1:0]));
        chk("model_ovf", 65'(out_ovf), OVF_ON ? 65'(mr[SL-1][W]) : 65'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (rec_on && !rst && out_valid) begin
      rec_cyc.push_back(cyc);
      rec_out.push_back(out);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic e, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    en = e; in_valid = v; in_sum = a; in_carry = b;
  endtask

  // One isolated op: out_valid must be high only on the 4th cycle after sampling
  task automatic single_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eo, input logic eovf);
    @(posedge clk); #1; drive(1'b1, 1'b1, a, b);
    @(posedge clk); #1; drive(1'b1, 1'b0, '0, '0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      chk({nm, "_vld"}, 65'(out_valid), 65'(c == 4));
      if (c == 4) begin
        chk({nm, "_out"}, 65'(out), 65'(eo));
        chk({nm, "_ovf"}, 65'(out_ovf), 65'(eovf));
      end
    end
  endtask

  initial begin
    int base;
    int n_acc;
    int mode;
    logic [W-1:0] a, b;

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    #7;
    chk("rst_vld", 65'(out_valid), 65'(0));
    chk("rst_out", 65'(out), 65'(0));
    chk("rst_ovf", 65'(out_ovf), 65'(0));
    #5;
    rst = 1'b0;
    model_on = 1'b1;

    single_op("add5_7", 64'd5, 64'd7, 64'd12, 1'b0);
    single_op("slice01", 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 1'b0);
    single_op("ripple3", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'h0001_0000_0000_0000, 1'b0);
    single_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, OVF_ON);

    // Back-to-back with a 2-cycle stall; garbage offered during the stall must be ignored
    rec_cyc.delete(); rec_out.delete();
    @(posedge clk); #1; base = cyc; rec_on = 1'b1;
    drive(1'b1, 1'b1, 64'd1, 64'd1);
    @(posedge clk); #1; drive(1'b1, 1'b1, 64'd2, 64'd2);
    @(posedge clk); #1; drive(1'b0, 1'b1, 64'd9, 64'd9);
    @(posedge clk); #1; drive(1'b0, 1'b1, 64'd9, 64'd9);
    @(posedge clk); #1; drive(1'b1, 1'b1, 64'd3, 64'd3);
    @(posedge clk); #1; drive(1'b1, 1'b0, '0, '0);
    repeat (7) @(posedge clk);
    @(negedge clk); #1; rec_on = 1'b0;
    chk("stall_cnt", 65'(rec_cyc.size()), 65'(3));
    for (int j = 0; j < 3; j++) begin
      if (j < rec_cyc.size()) begin
        chk("stall_cyc", 65'(rec_cyc[j]), 65'(base + 6 + j));
        chk("stall_out", 65'(rec_out[j]), 65'(2 * (j + 1)));
      end
    end

    // Asynchronous reset with ops in flight, then a fresh op after release
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 64'(10 * i), 64'(i));
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, '0, '0);
    #1;
    chk("prerst_vld", 65'(out_valid), 65'(1));
    chk("prerst_out", 65'(out), 65'(22));
    #1; rst = 1'b1;
    #1;
    chk("arst_vld", 65'(out_valid), 65'(0));
    chk("arst_out", 65'(out), 65'(0));
    chk("arst_ovf", 65'(out_ovf), 65'(0));
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    rec_cyc.delete(); rec_out.delete();
    base = cyc; rec_on = 1'b1;
    drive(1'b1, 1'b1, 64'd1, 64'd2);
    @(posedge clk); #1; drive(1'b1, 1'b0, '0, '0);
    repeat (8) @(posedge clk);
    @(negedge clk); #1; rec_on = 1'b0;
    chk("post_rst_cnt", 65'(rec_cyc.size()), 65'(1));
    if (rec_cyc.size() > 0) begin
      chk("post_rst_cyc", 65'(rec_cyc[0]), 65'(base + 4));
      chk("post_rst_out", 65'(rec_out[0]), 65'(3));
    end

    // Random operands and random stalls, checked by the model every cycle
    n_acc = 0;
    while (n_acc < 10000) begin
      @(posedge clk); #1;
      mode = int'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      case (mode)
        0: b = {$urandom, $urandom};
        1: begin a = '1; b = 64'($urandom_range(0, 3)); end
        2: b = (~a) + 64'($urandom_range(0, 1));
        default: begin a = a | 64'h0000_FFFF_0000_FFFF; b = 64'h0000_0001_0000_0001; end
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, a, b);
      if (en && in_valid) n_acc++;
    end
    @(posedge clk); #1; drive(1'b1, 1'b0, '0, '0);
    repeat (8) @(posedge clk);
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
